// File: rtl/ram_16x8_if.sv
// rtl/ram_16x8_if.sv - control/address bundle for the 16x8 RAM with MAR
//
// Purpose: groups the run-mode and program-mode control inputs of ram_16x8.
// The shared tri-state data bus is not part of this bundle because the RAM
// does not own it; it stays a plain inout on the RAM.
//
// Signals:
//   addr_in        [3:0]  run-mode address source for the MAR
//   addr_in_manual [3:0]  program-mode address (front-panel switches)
//   program_mode          1 = program (manual) mode, 0 = run mode
//   addr_en               run mode: load MAR from addr_in
//   load_manual           program mode: write data_in_manual
//   load                  run mode: write bus data
//   dataout_en            1 = RAM drives the data bus
//   data_in_manual [7:0]  program-mode write data
// Modports: master drives the controls, slave (the RAM) receives them.
interface ram_16x8_if;
   logic [3:0] addr_in;
   logic [3:0] addr_in_manual;
   logic       program_mode;
   logic       addr_en;
   logic       load_manual;
   logic       load;
   logic       dataout_en;
   logic [7:0] data_in_manual;

   modport master (
      output addr_in, addr_in_manual, program_mode, addr_en,
             load_manual, load, dataout_en, data_in_manual
   );

   modport slave (
      input  addr_in, addr_in_manual, program_mode, addr_en,
             load_manual, load, dataout_en, data_in_manual
   );
endinterface

// File: rtl/ram_16x8.sv
// rtl/ram_16x8.sv - 16-word x 8-bit RAM with memory address register
//
// Purpose: bus-side RAM for the 8-bit bus processor. In run mode the word is
// addressed by the MAR and written from the shared bus; in program mode it is
// addressed and written from the front-panel inputs. Reads are combinational
// onto the tri-state bus whenever dataout_en is high.
//
// Ports:
//   clk         system clock, rising-edge active
//   addr_clr_n  asynchronous active-low clear of the MAR only
//   ctrl        ram_16x8_if.slave control/address bundle
//   data [7:0]  shared tri-state data bus
module ram_16x8 (
   input  logic        clk,
   input  logic        addr_clr_n,
   ram_16x8_if.slave   ctrl,
   inout  wire  [7:0]  data
);

   logic [3:0] mar_q;
   logic [3:0] mar_d;
   logic [7:0] mem_q [16];

   logic [3:0] sel;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;

   // MAR only follows addr_in in run mode; in program mode it keeps the
   // run-mode address so execution resumes where it left off.
   always_comb begin
      mar_d = mar_q;
      if (!ctrl.program_mode && ctrl.addr_en) begin
         mar_d = ctrl.addr_in;
      end
   end

   always_ff @(posedge clk or negedge addr_clr_n) begin
      if (!addr_clr_n) begin
         mar_q <= 4'h0;
      end else begin
         mar_q <= mar_d;
      end
   end

   // Write port select. A run-mode write is suppressed while the RAM drives
   // the bus, since the bus then carries our own read data. The run-mode
   // address is the pre-edge MAR, so a simultaneous addr_en/load writes the
   // old location.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = mar_q;
      wr_data = data;
      if (ctrl.program_mode) begin
         if (ctrl.load_manual) begin
            wr_en   = 1'b1;
            wr_addr = ctrl.addr_in_manual;
            wr_data = ctrl.data_in_manual;
         end
      end else if (ctrl.load && !ctrl.dataout_en) begin
         wr_en   = 1'b1;
         wr_addr = mar_q;
         wr_data = data;
      end
   end

   // Storage has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign sel  = ctrl.program_mode ? ctrl.addr_in_manual : mar_q;
   assign data = ctrl.dataout_en ? mem_q[sel] : 8'hzz;

endmodule

// File: tb/tb_ram_16x8.sv
// tb/tb_ram_16x8.sv - self-checking bench for ram_16x8
module tb_ram_16x8;

   logic       clk;
   logic       addr_clr_n;
   logic [7:0] drv;
   logic       drv_en;
   wire  [7:0] data;

   ram_16x8_if ram_if ();

   assign data = drv_en ? drv : 8'hzz;

   ram_16x8 dut (
      .clk        (clk),
      .addr_clr_n (addr_clr_n),
      .ctrl       (ram_if.slave),
      .data       (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem_m [16];
   bit         written [16];
   logic [3:0] mar_m;

   task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", tag, act, exp);
      end
   endtask

   // Reference model step for one rising edge, computed from the pre-edge
   // inputs, then advance to the following falling edge.
   task automatic tick();
      bit         we;
      logic [3:0] wa;
      logic [7:0] wd;
      we = 0;
      wa = 4'h0;
      wd = 8'h00;
      if (ram_if.program_mode) begin
         if (ram_if.load_manual) begin
            we = 1; wa = ram_if.addr_in_manual; wd = ram_if.data_in_manual;
         end
      end else if (ram_if.load && !ram_if.dataout_en) begin
         we = 1; wa = (addr_clr_n ? mar_m : 4'h0); wd = drv;
      end
      if (addr_clr_n && !ram_if.program_mode && ram_if.addr_en) mar_m = ram_if.addr_in;
      if (!addr_clr_n) mar_m = 4'h0;
      if (we) begin
         mem_m[wa] = wd;
         written[wa] = 1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_ctrl();
      ram_if.addr_en     = 1'b0;
      ram_if.load        = 1'b0;
      ram_if.load_manual = 1'b0;
      drv_en             = 1'b0;
   endtask

   initial begin
      logic [3:0] s;
      for (int i = 0; i < 16; i++) written[i] = 0;
      mar_m = 4'h0;
      addr_clr_n = 1'b0;
      drv = 8'h00;
      drv_en = 1'b0;
      ram_if.addr_in = 4'h0;
      ram_if.addr_in_manual = 4'h0;
      ram_if.program_mode = 1'b0;
      ram_if.addr_en = 1'b0;
      ram_if.load_manual = 1'b0;
      ram_if.load = 1'b0;
      ram_if.dataout_en = 1'b0;
      ram_if.data_in_manual = 8'h00;
      @(negedge clk);
      @(negedge clk);

      // Bus released after reset: another driver's value is seen unaltered.
      drv_en = 1'b1; drv = 8'h00;
      #1 check_eq("reset_bus_free", data, 8'h00);
      drv_en = 1'b0;
      addr_clr_n = 1'b1;
      @(negedge clk);

      // Manual writes: 0 -> 0A, 1 -> 1B, 7 -> E7.
      ram_if.program_mode = 1'b1;
      ram_if.load_manual = 1'b1;
      ram_if.addr_in_manual = 4'h0; ram_if.data_in_manual = 8'h0A; tick();
      ram_if.addr_in_manual = 4'h1; ram_if.data_in_manual = 8'h1B; tick();
      ram_if.addr_in_manual = 4'h7; ram_if.data_in_manual = 8'hE7; tick();
      ram_if.load_manual = 1'b0;
      ram_if.dataout_en = 1'b1;
      ram_if.addr_in_manual = 4'h0;
      #1 check_eq("manual_rd0", data, 8'h0A);
      ram_if.addr_in_manual = 4'h1;
      #1 check_eq("manual_rd1_noclk", data, 8'h1B);

      // Run-mode write of AA to address A.
      @(negedge clk);
      ram_if.program_mode = 1'b0;
      ram_if.dataout_en = 1'b0;
      ram_if.addr_in = 4'hA; ram_if.addr_en = 1'b1; tick();
      ram_if.addr_en = 1'b0;
      drv_en = 1'b1; drv = 8'hAA; ram_if.load = 1'b1; tick();
      idle_ctrl();
      ram_if.dataout_en = 1'b1;
      #1 check_eq("run_write", data, 8'hAA);

      // MAR hold, then reload.
      ram_if.addr_in = 4'h1; tick();
      check_eq("mar_hold", data, 8'hAA);
      ram_if.addr_en = 1'b1; tick();
      ram_if.addr_en = 1'b0;
      #1 check_eq("mar_reload", data, 8'h1B);

      // Asynchronous clear between edges.
      #1 addr_clr_n = 1'b0; mar_m = 4'h0;
      #1 check_eq("async_clear", data, 8'h0A);
      addr_clr_n = 1'b1;
      @(negedge clk);
      ram_if.addr_in = 4'h1; ram_if.addr_en = 1'b1; tick();
      ram_if.addr_en = 1'b0;
      #1 check_eq("reload_after_clr", data, 8'h1B);

      // Write while held in reset targets address 0; addr_en ignored.
      addr_clr_n = 1'b0; mar_m = 4'h0;
      ram_if.dataout_en = 1'b0;
      ram_if.addr_in = 4'h5; ram_if.addr_en = 1'b1;
      drv_en = 1'b1; drv = 8'h3C; ram_if.load = 1'b1; tick();
      idle_ctrl();
      addr_clr_n = 1'b1;
      ram_if.dataout_en = 1'b1;
      #1 check_eq("write_in_reset", data, 8'h3C);

      // Simultaneous addr_en + load: write uses old MAR (0), MAR -> 7.
      @(negedge clk);
      ram_if.dataout_en = 1'b0;
      ram_if.addr_in = 4'h7; ram_if.addr_en = 1'b1;
      drv_en = 1'b1; drv = 8'h77; ram_if.load = 1'b1; tick();
      idle_ctrl();
      ram_if.dataout_en = 1'b1;
      #1 check_eq("simul_new_mar", data, 8'hE7);
      ram_if.program_mode = 1'b1; ram_if.addr_in_manual = 4'h0;
      #1 check_eq("simul_old_addr", data, 8'h77);
      ram_if.program_mode = 1'b0;
      #1 check_eq("mar_kept_mode", data, 8'hE7);

      // Contention: load while RAM drives must not write.
      @(negedge clk);
      drv_en = 1'b1; drv = 8'h18; ram_if.load = 1'b1; tick();
      idle_ctrl();
      #1 check_eq("no_write_driving", data, 8'hE7);
      ram_if.dataout_en = 1'b0;
      drv_en = 1'b1; drv = 8'h00;
      #1 check_eq("release_run", data, 8'h00);
      ram_if.program_mode = 1'b1; ram_if.addr_in_manual = 4'h7;
      #1 check_eq("release_prog", data, 8'h00);
      drv_en = 1'b0;

      // Program mode ignores load and addr_en.
      @(negedge clk);
      drv_en = 1'b1; drv = 8'h99; ram_if.load = 1'b1;
      ram_if.addr_in = 4'h2; ram_if.addr_en = 1'b1; tick();
      idle_ctrl();
      ram_if.program_mode = 1'b0; ram_if.dataout_en = 1'b1;
      #1 check_eq("prog_ignores_run", data, 8'hE7);

      // Run mode ignores load_manual.
      @(negedge clk);
      ram_if.load_manual = 1'b1; ram_if.addr_in_manual = 4'h7;
      ram_if.data_in_manual = 8'h66; tick();
      idle_ctrl();
      #1 check_eq("run_ignores_manual", data, 8'hE7);
      ram_if.program_mode = 1'b1;
      #1 check_eq("run_ignores_man_p", data, 8'hE7);

      // Randomized traffic against the reference model.
      @(negedge clk);
      for (int it = 0; it < 400; it++) begin
         ram_if.program_mode   = 1'($urandom_range(0, 1));
         ram_if.addr_en        = 1'($urandom_range(0, 1));
         ram_if.load           = 1'($urandom_range(0, 1));
         ram_if.load_manual    = 1'($urandom_range(0, 1));
         ram_if.dataout_en     = 1'($urandom_range(0, 2) == 0);
         ram_if.addr_in        = 4'($urandom);
         ram_if.addr_in_manual = 4'($urandom);
         ram_if.data_in_manual = 8'($urandom);
         drv                   = 8'($urandom);
         drv_en                = !ram_if.dataout_en;
         if ($urandom_range(0, 15) == 0) begin
            #1 addr_clr_n = 1'b0; mar_m = 4'h0;
            #1 addr_clr_n = 1'b1;
         end
         #1;
         s = ram_if.program_mode ? ram_if.addr_in_manual : mar_m;
         if (ram_if.dataout_en && written[s]) check_eq("rand_read", data, mem_m[s]);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
